calc_accumulator: RTL and testbench

//  Datapath responder for the calculator control FSM's toggle-command interface.

---
 rtl/calc_pkg.sv | 53 +++++
 rtl/toggle_sync.sv | 40 ++++
 rtl/calc_accumulator.sv | 114 +++++++++++
 tb/tb_calc_accumulator.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator accumulator datapath:
// command encoding, pending-flag bit positions and the priority encoder.
package calc_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 8;

  // Bit positions of each command inside the pending / event vectors
  localparam int PEND_RESET  = 0;
  localparam int PEND_UPDATE = 1;
  localparam int PEND_STORE  = 2;
  localparam int PEND_SHOW   = 3;
  localparam int NUM_CMDS    = 4;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_RESET,
    CMD_UPDATE,
    CMD_STORE,
    CMD_SHOW
  } cmd_e;

  // Pick the single command to run this cycle: reset > update > store > show
  function automatic cmd_e selectCmd(input logic [NUM_CMDS-1:0] pending);
    cmd_e cmd;
    cmd = CMD_NONE;
    if (pending[PEND_RESET]) begin
      cmd = CMD_RESET;
    end else if (pending[PEND_UPDATE]) begin
      cmd = CMD_UPDATE;
    end else if (pending[PEND_STORE]) begin
      cmd = CMD_STORE;
    end else if (pending[PEND_SHOW]) begin
      cmd = CMD_SHOW;
    end
    return cmd;
  endfunction

  // One-hot mask of the pending flag that a given command retires
  function automatic logic [NUM_CMDS-1:0] cmdMask(input cmd_e cmd);
    logic [NUM_CMDS-1:0] mask;
    mask = '0;
    case (cmd)
      CMD_RESET:  mask[PEND_RESET]  = 1'b1;
      CMD_UPDATE: mask[PEND_UPDATE] = 1'b1;
      CMD_STORE:  mask[PEND_STORE]  = 1'b1;
      CMD_SHOW:   mask[PEND_SHOW]   = 1'b1;
      default:    mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Toggle-command receiver: two-flop synchronizer followed by a change
// detector. Any change of level becomes a one-cycle event pulse.
// After reset the detector stays quiet until the synchronizer has refilled,
// so a line that was already resting high is not mistaken for a toggle.
module toggle_sync
  import calc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_event
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_fill;
  logic r_primed;

  // Synchronize the level, track its previous value and run the priming gate;
  // while unprimed, prev follows the value sync2 is about to take
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_prev   <= 1'b0;
      r_fill   <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_sync1  <= i_level;
      r_sync2  <= r_sync1;
      r_fill   <= 1'b1;
      r_primed <= r_fill;
      r_prev   <= r_primed ? r_sync2 : r_sync1;
    end
  end

  assign o_event = r_primed & (r_sync2 ^ r_prev);

endmodule

// File: rtl/calc_accumulator.sv
// Datapath responder for the calculator control FSM. Each toggle of
// update/show/store/reset is one command; commands are queued as pending
// flags and retired one per cycle in priority order. Owns total, operand,
// overflow, operation counter and the display source selection.
module calc_accumulator
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update,
  input  logic             show,
  input  logic             store,
  input  logic             reset,
  input  logic [WIDTH-1:0] number,
  output logic [WIDTH-1:0] total,
  output logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] display,
  output logic             show_total,
  output logic             overflow,
  output logic [CNT_W-1:0] op_count
);

  logic [NUM_CMDS-1:0] w_levels;
  logic [NUM_CMDS-1:0] w_event;
  logic [NUM_CMDS-1:0] w_effPending;
  logic [NUM_CMDS-1:0] w_pendingNext;
  logic [NUM_CMDS-1:0] r_pending;
  cmd_e                w_cmd;
  logic [WIDTH:0]      w_sum;

  logic [WIDTH-1:0]    r_total;
  logic [WIDTH-1:0]    r_operand;
  logic                r_showTotal;
  logic                r_overflow;
  logic [CNT_W-1:0]    r_opCount;

  assign w_levels[PEND_RESET]  = reset;
  assign w_levels[PEND_UPDATE] = update;
  assign w_levels[PEND_STORE]  = store;
  assign w_levels[PEND_SHOW]   = show;

  for (genvar g = 0; g < NUM_CMDS; g++) begin : g_sync
    toggle_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_level (w_levels[g]),
      .o_event (w_event[g])
    );
  end

  // A fresh event merges with the stored flags, so it can run in the cycle it
  // arrives and a repeat of an already-waiting command collapses into one
  assign w_effPending = r_pending | w_event;
  assign w_sum        = {1'b0, r_total} + {1'b0, r_operand};

  // Choose this cycle's command and work out which flags remain afterwards;
  // a reset command wipes everything, including events landing this cycle
  always_comb begin
    w_cmd         = selectCmd(w_effPending);
    w_pendingNext = w_effPending & ~cmdMask(w_cmd);
    if (w_cmd == CMD_RESET) begin
      w_pendingNext = '0;
    end
  end

  // Pending flags and arithmetic state; exactly one command retires per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_total     <= '0;
      r_operand   <= '0;
      r_showTotal <= 1'b0;
      r_overflow  <= 1'b0;
      r_opCount   <= '0;
    end else begin
      r_pending <= w_pendingNext;
      case (w_cmd)
        CMD_RESET: begin
          r_total     <= '0;
          r_operand   <= '0;
          r_showTotal <= 1'b0;
          r_overflow  <= 1'b0;
          r_opCount   <= '0;
        end
        CMD_UPDATE: begin
          r_total    <= w_sum[WIDTH-1:0];
          r_overflow <= r_overflow | w_sum[WIDTH];
          if (r_opCount != '1) begin
            r_opCount <= r_opCount + CNT_W'(1);
          end
        end
        CMD_STORE: begin
          r_operand <= number;
        end
        CMD_SHOW: begin
          r_showTotal <= ~r_showTotal;
        end
        default: begin
        end
      endcase
    end
  end

  assign total      = r_total;
  assign operand    = r_operand;
  assign show_total = r_showTotal;
  assign overflow   = r_overflow;
  assign op_count   = r_opCount;
  assign display    = r_showTotal ? r_total : r_operand;

endmodule

// File: tb/tb_calc_accumulator.sv
// Self-checking bench for calc_accumulator. Stimulus tasks toggle command
// lines, run an abstract calculator model and queue the expected outputs for
// every following clock edge; an independent monitor compares them.
module tb_calc_accumulator;

  localparam int WIDTH   = 16;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int MODULUS = 1 << WIDTH;

  localparam int C_RESET  = 0;
  localparam int C_UPDATE = 1;
  localparam int C_STORE  = 2;
  localparam int C_SHOW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             update;
  logic             show;
  logic             store;
  logic             reset;
  logic [WIDTH-1:0] number;
  logic [WIDTH-1:0] total;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] display;
  logic             show_total;
  logic             overflow;
  logic [CNT_W-1:0] op_count;

  calc_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .update     (update),
    .show       (show),
    .store      (store),
    .reset      (reset),
    .number     (number),
    .total      (total),
    .operand    (operand),
    .display    (display),
    .show_total (show_total),
    .overflow   (overflow),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int total;
    int operand;
    int ovf;
    int showT;
    int cnt;
  } expect_t;

  expect_t sbQueue[$];
  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  int mTotal, mOperand, mOvf, mShow, mCount;

  // Edge counter: at a falling edge it holds the number of the last rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Abstract calculator: what each command does to the visible state
  function automatic void modelExec(input int cmd, input int num);
    int sum;
    case (cmd)
      C_RESET: begin
        mTotal = 0; mOperand = 0; mOvf = 0; mShow = 0; mCount = 0;
      end
      C_UPDATE: begin
        sum    = mTotal + mOperand;
        mTotal = sum % MODULUS;
        if (sum >= MODULUS) mOvf = 1;
        if (mCount < CNT_MAX) mCount = mCount + 1;
      end
      C_STORE: mOperand = num % MODULUS;
      C_SHOW:  mShow = 1 - mShow;
      default: ;
    endcase
  endfunction

  function automatic void pushState(input int c);
    sbQueue.push_back('{c, mTotal, mOperand, mOvf, mShow, mCount});
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: actual=%0d expected=%0d", name, cyc, actual, expected);
    end
  endtask

  // Monitor: compare the outputs against the scoreboard entry for this edge
  always @(negedge clk) begin
    expect_t e;
    if (sbQueue.size() > 0 && sbQueue[0].cyc == cyc) begin
      e = sbQueue.pop_front();
      checkOutput("total",      int'(total),      e.total);
      checkOutput("operand",    int'(operand),    e.operand);
      checkOutput("overflow",   int'(overflow),   e.ovf);
      checkOutput("show_total", int'(show_total), e.showT);
      checkOutput("op_count",   int'(op_count),   e.cnt);
      checkOutput("display",    int'(display),    (e.showT != 0) ? e.total : e.operand);
    end
  end

  // Toggle a set of command lines together; commands land three edges later,
  // one per edge in priority order (a reset command swallows the others)
  task automatic applyStimulus(input bit u, input bit s, input bit h, input bit r,
                               input int num, input int len);
    int c;
    int order[$];
    number = WIDTH'(num);
    if (u) update = ~update;
    if (s) store  = ~store;
    if (h) show   = ~show;
    if (r) reset  = ~reset;
    c = cyc;
    if (r) order.push_back(C_RESET);
    else begin
      if (u) order.push_back(C_UPDATE);
      if (s) order.push_back(C_STORE);
      if (h) order.push_back(C_SHOW);
    end
    for (int k = 1; k <= len; k++) begin
      if (k >= 3 && (k - 3) < order.size()) modelExec(order[k-3], num);
      pushState(c + k);
    end
    repeat (len) @(negedge clk);
  endtask

  // Hold the hardware reset for some edges, then let the block idle
  task automatic doRst(input int hold, input int idle);
    int c;
    rst = 1'b1;
    c   = cyc;
    modelExec(C_RESET, 0);
    for (int k = 1; k <= hold + idle; k++) pushState(c + k);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  // Toggle update, then hit the hardware reset before it can execute
  task automatic rstMidSequence();
    update = ~update;
    pushState(cyc + 1);
    @(negedge clk);
    doRst(1, 6);
  endtask

  // A second store toggle while store is still waiting behind update must
  // merge into the first; a later number change must not be captured
  task automatic absorbTest(input int a, input int b);
    int c;
    number = WIDTH'(a);
    update = ~update;
    store  = ~store;
    c = cyc;
    pushState(c + 1);
    pushState(c + 2);
    modelExec(C_UPDATE, a);
    pushState(c + 3);
    modelExec(C_STORE, a);
    for (int k = 4; k <= 9; k++) pushState(c + k);
    @(negedge clk);
    store = ~store;
    repeat (3) @(negedge clk);
    number = WIDTH'(b);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst    = 1'b1;
    update = 1'b1;
    show   = 1'b1;
    store  = 1'b1;
    reset  = 1'b1;
    number = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset with all toggles resting high");
    doRst(2, 10);

    $display("[TB] store 5, then store 7 together with update");
    applyStimulus(0, 1, 0, 0, 5, 8);
    applyStimulus(1, 1, 0, 0, 7, 8);

    $display("[TB] overflow boundary");
    doRst(1, 4);
    applyStimulus(0, 1, 0, 0, 2, 6);
    applyStimulus(1, 0, 0, 0, 0, 6);
    applyStimulus(0, 1, 0, 0, 16'hFFFF, 6);
    applyStimulus(1, 0, 0, 0, 0, 6);
    applyStimulus(0, 1, 0, 0, 1, 6);
    applyStimulus(1, 0, 0, 0, 0, 6);

    $display("[TB] show toggles");
    applyStimulus(0, 0, 1, 0, 0, 6);
    applyStimulus(0, 0, 1, 0, 0, 6);

    $display("[TB] all four commands at once");
    applyStimulus(0, 1, 0, 0, 9, 6);
    applyStimulus(1, 1, 1, 1, 3, 8);

    $display("[TB] repeated command absorbed while waiting");
    absorbTest(16'h1234, 16'h4321);

    $display("[TB] counter saturation and reset mid-sequence");
    doRst(1, 4);
    applyStimulus(0, 1, 0, 0, 1, 5);
    for (int i = 0; i < CNT_MAX + 5; i++) applyStimulus(1, 0, 0, 0, 0, 4);
    rstMidSequence();

    $display("[TB] randomized command bursts");
    for (int i = 0; i < 120; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, MODULUS - 1)), 8);
      if (i % 40 == 39) rstMidSequence();
    end

    for (int i = 0; i < 50 && sbQueue.size() > 0; i++) @(negedge clk);
    checkOutput("scoreboard_drain", sbQueue.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
